// File: rtl/conv_cores_pkg.sv
// Shared constants, accumulator type and operating-mode enum for the multi-core convolution engine.
package conv_cores_pkg;

    localparam int CORES_DEF       = 4;
    localparam int CONV_UNITS_DEF  = 8;
    localparam int DATA_WIDTH_DEF  = 16;
    localparam int ACC_WIDTH_DEF   = 40;
    localparam int TUSER_WIDTH_DEF = 8;

    typedef logic signed [ACC_WIDTH_DEF-1:0] acc_t;

    typedef enum logic {
        MODE_CONV = 1'b0,
        MODE_MAX  = 1'b1
    } mode_e;

endpackage

// File: rtl/conv_mac_lane.sv
// One core's bank of CONV_UNITS accumulators: multiply-accumulate against a single weight,
// or running signed max of the pixels when in max-pool mode.
module conv_mac_lane
    import conv_cores_pkg::*;
#(
    parameter int CONV_UNITS = CONV_UNITS_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ACC_WIDTH  = ACC_WIDTH_DEF
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                i_fire,
    input  logic                                i_first,
    input  mode_e                               i_mode,
    input  logic [CONV_UNITS*DATA_WIDTH-1:0]    i_pix,
    input  logic signed [DATA_WIDTH-1:0]        i_wgt,
    output logic [CONV_UNITS*ACC_WIDTH-1:0]     o_acc_next
);

    for (genvar u = 0; u < CONV_UNITS; u++) begin : g_unit
        logic signed [DATA_WIDTH-1:0]   w_pix;
        logic signed [2*DATA_WIDTH-1:0] w_prod;
        logic signed [ACC_WIDTH-1:0]    w_pix_ext;
        logic signed [ACC_WIDTH-1:0]    w_prod_ext;
        logic signed [ACC_WIDTH-1:0]    w_base;
        logic signed [ACC_WIDTH-1:0]    w_next;
        logic signed [ACC_WIDTH-1:0]    r_acc;

        // Full-width product then sign extension; the accumulator wraps on overflow.
        assign w_pix      = $signed(i_pix[u*DATA_WIDTH +: DATA_WIDTH]);
        assign w_prod     = (2*DATA_WIDTH)'(w_pix) * (2*DATA_WIDTH)'(i_wgt);
        assign w_pix_ext  = ACC_WIDTH'(w_pix);
        assign w_prod_ext = ACC_WIDTH'(w_prod);
        assign w_base     = i_first ? ACC_WIDTH'(0) : r_acc;

        always_comb begin
            if (i_mode == MODE_MAX) begin
                w_next = (i_first || (w_pix_ext > r_acc)) ? w_pix_ext : r_acc;
            end else begin
                w_next = w_base + w_prod_ext;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_acc <= '0;
            end else if (i_fire) begin
                r_acc <= w_next;
            end
        end

        assign o_acc_next[u*ACC_WIDTH +: ACC_WIDTH] = w_next;
    end

endmodule

// File: rtl/axis_conv_cores.sv
// Multi-core convolution engine: joins pixel and weight beats, accumulates per group, emits a
// backpressured result beat. Optional ReLU clamp built only when CONV_CORES_RELU_EN is defined.
module axis_conv_cores
    import conv_cores_pkg::*;
#(
    parameter int CORES       = CORES_DEF,
    parameter int CONV_UNITS  = CONV_UNITS_DEF,
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int ACC_WIDTH   = ACC_WIDTH_DEF,
    parameter int TUSER_WIDTH = TUSER_WIDTH_DEF
) (
    input  logic                                   aclk,
    input  logic                                   aresetn,
    input  logic                                   start,
    input  logic                                   is_max,
    input  logic                                   is_relu,
    input  logic                                   pixels_s_valid,
    output logic                                   pixels_s_ready,
    input  logic [CONV_UNITS*DATA_WIDTH-1:0]       pixels_s_data,
    input  logic                                   pixels_s_last,
    input  logic                                   pixels_s_frame_last,
    input  logic [TUSER_WIDTH-1:0]                 pixels_s_user,
    input  logic                                   weights_s_valid,
    output logic                                   weights_s_ready,
    input  logic [CORES*DATA_WIDTH-1:0]            weights_s_data,
    output logic                                   m_valid,
    input  logic                                   m_ready,
    output logic [CORES*CONV_UNITS*ACC_WIDTH-1:0]  m_data,
    output logic                                   m_last,
    output logic [TUSER_WIDTH-1:0]                 m_user
);

    localparam int OUT_W = CORES*CONV_UNITS*ACC_WIDTH;

    function automatic logic [ACC_WIDTH-1:0] relu_clamp(input logic [ACC_WIDTH-1:0] v,
                                                        input logic en);
        return (en && v[ACC_WIDTH-1]) ? '0 : v;
    endfunction

    mode_e                   r_mode;
    logic                    r_first;
    logic                    r_m_valid;
    logic [OUT_W-1:0]        r_m_data;
    logic                    r_m_last;
    logic [TUSER_WIDTH-1:0]  r_m_user;

    logic                    w_slot_ok;
    logic                    w_accept;
    logic                    w_is_max;
    logic                    w_fire;
    logic                    w_last_fire;
    logic                    w_relu_on;
    logic [OUT_W-1:0]        w_acc_next;
    logic [OUT_W-1:0]        w_result;

`ifdef CONV_CORES_RELU_EN
    logic r_relu;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_relu <= 1'b0;
        end else if (start) begin
            r_relu <= is_relu;
        end
    end

    assign w_relu_on = r_relu;
`else
    logic w_unused_relu;

    assign w_unused_relu = is_relu;
    assign w_relu_on     = 1'b0;
`endif

    // Only a last beat needs the output slot; readies are forced low while in reset.
    assign w_slot_ok       = !r_m_valid || m_ready;
    assign w_accept        = aresetn && (!pixels_s_last || w_slot_ok);
    assign w_is_max        = (r_mode == MODE_MAX);
    assign pixels_s_ready  = w_accept && (w_is_max || weights_s_valid);
    assign weights_s_ready = w_accept && !w_is_max && pixels_s_valid;
    assign w_fire          = pixels_s_valid && pixels_s_ready;
    assign w_last_fire     = w_fire && pixels_s_last;

    for (genvar c = 0; c < CORES; c++) begin : g_core
        conv_mac_lane #(
            .CONV_UNITS (CONV_UNITS),
            .DATA_WIDTH (DATA_WIDTH),
            .ACC_WIDTH  (ACC_WIDTH)
        ) u_lane (
            .clk        (aclk),
            .rst_n      (aresetn),
            .i_fire     (w_fire),
            .i_first    (r_first),
            .i_mode     (r_mode),
            .i_pix      (pixels_s_data),
            .i_wgt      (weights_s_data[c*DATA_WIDTH +: DATA_WIDTH]),
            .o_acc_next (w_acc_next[c*CONV_UNITS*ACC_WIDTH +: CONV_UNITS*ACC_WIDTH])
        );
    end

    for (genvar i = 0; i < CORES*CONV_UNITS; i++) begin : g_res
        assign w_result[i*ACC_WIDTH +: ACC_WIDTH] =
            relu_clamp(w_acc_next[i*ACC_WIDTH +: ACC_WIDTH], w_relu_on);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_mode  <= MODE_CONV;
            r_first <= 1'b1;
        end else begin
            if (start) begin
                r_mode <= mode_e'(is_max);
            end
            // start wins so a beat firing alongside it cannot clear the fresh-group flag.
            if (start) begin
                r_first <= 1'b1;
            end else if (w_fire) begin
                r_first <= pixels_s_last;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
            r_m_last  <= 1'b0;
            r_m_user  <= '0;
        end else if (w_last_fire) begin
            r_m_valid <= 1'b1;
            r_m_data  <= w_result;
            r_m_last  <= pixels_s_frame_last;
            r_m_user  <= pixels_s_user;
        end else if (m_ready) begin
            r_m_valid <= 1'b0;
        end
    end

    assign m_valid = r_m_valid;
    assign m_data  = r_m_data;
    assign m_last  = r_m_last;
    assign m_user  = r_m_user;

endmodule

// File: tb/tb_axis_conv_cores.sv
// Directed scoreboard bench for axis_conv_cores: expected results are queued at stimulus time
// and popped by an independent output monitor.
module tb_axis_conv_cores;

    localparam int CORES = 4;
    localparam int CU    = 8;
    localparam int DW    = 16;
    localparam int AW    = 40;
    localparam int UW    = 8;
    localparam int MW    = CORES*CU*AW;

    logic            aclk = 1'b0;
    logic            aresetn = 1'b0;
    logic            start = 1'b0;
    logic            is_max = 1'b0;
    logic            is_relu = 1'b0;
    logic            pixels_s_valid = 1'b0;
    logic            pixels_s_ready;
    logic [CU*DW-1:0] pixels_s_data = '0;
    logic            pixels_s_last = 1'b0;
    logic            pixels_s_frame_last = 1'b0;
    logic [UW-1:0]   pixels_s_user = '0;
    logic            weights_s_valid = 1'b0;
    logic            weights_s_ready;
    logic [CORES*DW-1:0] weights_s_data = '0;
    logic            m_valid;
    logic            m_ready = 1'b0;
    logic [MW-1:0]   m_data;
    logic            m_last;
    logic [UW-1:0]   m_user;

    axis_conv_cores #(
        .CORES(CORES), .CONV_UNITS(CU), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .TUSER_WIDTH(UW)
    ) dut (
        .aclk(aclk), .aresetn(aresetn), .start(start), .is_max(is_max), .is_relu(is_relu),
        .pixels_s_valid(pixels_s_valid), .pixels_s_ready(pixels_s_ready),
        .pixels_s_data(pixels_s_data), .pixels_s_last(pixels_s_last),
        .pixels_s_frame_last(pixels_s_frame_last), .pixels_s_user(pixels_s_user),
        .weights_s_valid(weights_s_valid), .weights_s_ready(weights_s_ready),
        .weights_s_data(weights_s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last), .m_user(m_user)
    );

    always #5 aclk = ~aclk;

    typedef struct packed {
        logic [MW-1:0] data;
        logic          last;
        logic [UW-1:0] user;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad = 0;
    int   pix_v[CU];
    int   w_v[CORES];
    int   exp_m[CORES][CU];
    logic [MW-1:0] exp_a;

    task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic check_data(input string name, input logic [MW-1:0] act, input logic [MW-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            for (int i = 0; i < CORES*CU; i++) begin
                if (act[i*AW +: AW] !== req[i*AW +: AW]) begin
                    $display("FAIL %s: core %0d unit %0d got %0d expected %0d", name, i / CU, i % CU,
                             $signed(act[i*AW +: AW]), $signed(req[i*AW +: AW]));
                    break;
                end
            end
        end
    endtask

    function automatic logic [MW-1:0] pack_exp();
        logic [MW-1:0] r;
        r = '0;
        for (int c = 0; c < CORES; c++)
            for (int u = 0; u < CU; u++)
                r[(c*CU+u)*AW +: AW] = AW'(exp_m[c][u]);
        return r;
    endfunction

    task automatic push_exp(input logic last, input logic [UW-1:0] user);
        exp_t e;
        e.data = pack_exp();
        e.last = last;
        e.user = user;
        sb_q.push_back(e);
    endtask

    task automatic apply_beat(input logic last, input logic flast, input logic [UW-1:0] user,
                              input logic use_w);
        for (int u = 0; u < CU; u++) pixels_s_data[u*DW +: DW] = DW'(pix_v[u]);
        for (int c = 0; c < CORES; c++) weights_s_data[c*DW +: DW] = DW'(w_v[c]);
        pixels_s_valid      = 1'b1;
        weights_s_valid     = use_w;
        pixels_s_last       = last;
        pixels_s_frame_last = flast;
        pixels_s_user       = user;
    endtask

    task automatic wait_fire(input string name);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(negedge aclk);
            if (pixels_s_ready) begin
                ok = 1'b1;
                break;
            end
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: beat not accepted, got no ready in 50 cycles, expected ready", name);
        end
        @(posedge aclk);
        #1;
        pixels_s_valid  = 1'b0;
        weights_s_valid = 1'b0;
        pixels_s_last   = 1'b0;
    endtask

    task automatic send(input string name, input logic last, input logic flast,
                        input logic [UW-1:0] user, input logic use_w);
        apply_beat(last, flast, user, use_w);
        wait_fire(name);
    endtask

    task automatic pulse_start(input logic mx, input logic rl);
        start   = 1'b1;
        is_max  = mx;
        is_relu = rl;
        @(posedge aclk);
        #1;
        start = 1'b0;
    endtask

    always @(negedge aclk) begin
        if (aresetn && m_valid && m_ready) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_output: got user %0h with no result expected", m_user);
            end else begin
                mon_e = sb_q.pop_front();
                check_data("m_data", m_data, mon_e.data);
                check_val("m_last", 64'(m_last), 64'(mon_e.last));
                check_val("m_user", 64'(m_user), 64'(mon_e.user));
            end
        end
    end

    initial begin
        // Reset with valids asserted: readies must stay low.
        pixels_s_valid = 1'b1; weights_s_valid = 1'b1; pixels_s_last = 1'b1; m_ready = 1'b1;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check_val("rst_m_valid", 64'(m_valid), 64'd0);
        check_data("rst_m_data", m_data, '0);
        check_val("rst_m_last", 64'(m_last), 64'd0);
        check_val("rst_m_user", 64'(m_user), 64'd0);
        check_val("rst_pix_ready", 64'(pixels_s_ready), 64'd0);
        check_val("rst_wgt_ready", 64'(weights_s_ready), 64'd0);
        pixels_s_valid = 1'b0; weights_s_valid = 1'b0; pixels_s_last = 1'b0;
        @(posedge aclk); #1;
        aresetn = 1'b1;
        @(posedge aclk); #1;

        // Conv, 3-beat group
        for (int u = 0; u < CU; u++) pix_v[u] = u + 1;
        w_v = '{1, 2, 3, 4};
        for (int c = 0; c < CORES; c++) for (int u = 0; u < CU; u++) exp_m[c][u] = 3*(u+1)*(c+1);
        send("conv_b1", 1'b0, 1'b0, 8'h00, 1'b1);
        send("conv_b2", 1'b0, 1'b0, 8'h00, 1'b1);
        check_val("conv_valid_before_last", 64'(m_valid), 64'd0);
        push_exp(1'b1, 8'hA5);
        send("conv_b3", 1'b1, 1'b1, 8'hA5, 1'b1);
        check_val("conv_latency_valid", 64'(m_valid), 64'd1);
        @(posedge aclk); #1;

        // Max-pool mode, weights never offered
        pulse_start(1'b1, 1'b0);
        for (int c = 0; c < CORES; c++) for (int u = 0; u < CU; u++) exp_m[c][u] = 7 + u;
        for (int b = 0; b < 3; b++) begin
            for (int u = 0; u < CU; u++) pix_v[u] = ((b == 0) ? -5 : (b == 1) ? 7 : 2) + u;
            if (b == 2) push_exp(1'b0, 8'h3C);
            apply_beat(b == 2, 1'b0, 8'h3C, 1'b0);
            #1;
            check_val("max_wgt_ready", 64'(weights_s_ready), 64'd0);
            wait_fire("max_beat");
        end
        @(posedge aclk); #1;

        // Backpressure: group A held while group B accumulates, B's last beat stalls
        pulse_start(1'b0, 1'b0);
        m_ready = 1'b0;
        for (int u = 0; u < CU; u++) pix_v[u] = u + 1;
        w_v = '{1, -1, 2, -2};
        for (int c = 0; c < CORES; c++) for (int u = 0; u < CU; u++) exp_m[c][u] = (u+1)*w_v[c];
        exp_a = pack_exp();
        push_exp(1'b0, 8'h11);
        send("bp_a", 1'b1, 1'b0, 8'h11, 1'b1);
        w_v = '{1, 2, 3, 4};
        send("bp_b1_nonlast", 1'b0, 1'b0, 8'h00, 1'b1);
        for (int u = 0; u < CU; u++) pix_v[u] = 10;
        w_v = '{1, 1, 1, 1};
        send("bp_b2_nonlast", 1'b0, 1'b0, 8'h00, 1'b1);
        for (int u = 0; u < CU; u++) pix_v[u] = -1;
        w_v = '{5, 5, 5, 5};
        apply_beat(1'b1, 1'b1, 8'h22, 1'b1);
        repeat (3) begin
            @(negedge aclk);
            check_val("bp_stall_ready", 64'(pixels_s_ready), 64'd0);
            check_val("bp_hold_valid", 64'(m_valid), 64'd1);
            check_data("bp_held_data", m_data, exp_a);
        end
        @(posedge aclk); #1;
        for (int c = 0; c < CORES; c++) for (int u = 0; u < CU; u++) exp_m[c][u] = (u+1)*(c+1) + 5;
        push_exp(1'b1, 8'h22);
        m_ready = 1'b1;
        wait_fire("bp_b3_last");
        check_val("bp_overwrite_valid", 64'(m_valid), 64'd1);
        @(posedge aclk); #1;

        // ReLU clamp on negative results only
        pulse_start(1'b0, 1'b1);
        for (int u = 0; u < CU; u++) pix_v[u] = (u % 2 == 0) ? -3 : 3;
        w_v = '{2, 2, 2, 2};
        for (int c = 0; c < CORES; c++)
            for (int u = 0; u < CU; u++)
`ifdef CONV_CORES_RELU_EN
                exp_m[c][u] = (u % 2 == 0) ? 0 : 6;
`else
                exp_m[c][u] = (u % 2 == 0) ? -6 : 6;
`endif
        push_exp(1'b0, 8'h44);
        send("relu_beat", 1'b1, 1'b0, 8'h44, 1'b1);
        @(posedge aclk); #1;

        // start discards a partial group
        pulse_start(1'b0, 1'b0);
        for (int u = 0; u < CU; u++) pix_v[u] = 1;
        w_v = '{1, 1, 1, 1};
        send("abort_b1", 1'b0, 1'b0, 8'h00, 1'b1);
        send("abort_b2", 1'b0, 1'b0, 8'h00, 1'b1);
        pulse_start(1'b0, 1'b0);
        for (int c = 0; c < CORES; c++) for (int u = 0; u < CU; u++) exp_m[c][u] = 4;
        for (int b = 0; b < 4; b++) begin
            if (b == 3) push_exp(1'b1, 8'h66);
            send("abort_after", b == 3, 1'b1, 8'h66, 1'b1);
        end
        @(posedge aclk); #1;

        // Reset mid-group with a result pending
        m_ready = 1'b0;
        for (int u = 0; u < CU; u++) pix_v[u] = u + 1;
        send("rst_pending", 1'b1, 1'b1, 8'h77, 1'b1);
        check_val("rst_pending_valid", 64'(m_valid), 64'd1);
        send("rst_partial", 1'b0, 1'b0, 8'h00, 1'b1);
        apply_beat(1'b0, 1'b0, 8'h00, 1'b1);
        aresetn = 1'b0;
        #1;
        check_val("mid_rst_valid", 64'(m_valid), 64'd0);
        check_data("mid_rst_data", m_data, '0);
        check_val("mid_rst_last", 64'(m_last), 64'd0);
        check_val("mid_rst_user", 64'(m_user), 64'd0);
        check_val("mid_rst_pix_ready", 64'(pixels_s_ready), 64'd0);
        pixels_s_valid = 1'b0; weights_s_valid = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        @(posedge aclk); #1;
        m_ready = 1'b1;
        w_v = '{1, 2, 3, 4};
        for (int c = 0; c < CORES; c++) for (int u = 0; u < CU; u++) exp_m[c][u] = 2*(u+1)*(c+1);
        send("post_rst_b1", 1'b0, 1'b0, 8'h00, 1'b1);
        push_exp(1'b1, 8'h5A);
        send("post_rst_b2", 1'b1, 1'b1, 8'h5A, 1'b1);
        repeat (5) @(posedge aclk);
        #1;
        check_val("scoreboard_empty", 64'(sb_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axis_conv_cores.md
# axis_conv_cores

Multi-core convolution engine with a backpressured AXI-Stream output. It sits after the pixel shift buffer and replaces the single-core, output-unstallable engine stage. It joins one pixel beat (CONV_UNITS pixels) with one weight beat (CORES weights), and accumulates every pixel×weight product per core and unit over a group of beats. At group end it emits a CORES×CONV_UNITS result beat, and can also run a max-pool mode that ignores weights.

## Interface
- CORES, 4: number of independent filters (weight lanes) processed in parallel.
- CONV_UNITS, 8: pixels per beat (output rows).
- DATA_WIDTH, 16: signed pixel and weight width.
- ACC_WIDTH, 40: signed accumulator and output width; must be ≥ 2·DATA_WIDTH.
- TUSER_WIDTH, 8: sideband passed from the group's last beat to the output.

Ports (clock and reset first):
- aclk  in  1  clock; the only clock.
- aresetn  in  1  asynchronous, active-low reset.
- start  in  1  pulse; latches is_max and is_relu, and aborts any partial group.
- is_max  in  1  max-pool mode when latched high.
- is_relu  in  1  clamps negative results to 0 when latched high.
- pixels_s_valid / pixels_s_ready  in/out  1  pixel handshake.
- pixels_s_data  in  CONV_UNITS×DATA_WIDTH  signed pixels.
- pixels_s_last  in  1  last beat of an accumulation group.
- pixels_s_frame_last  in  1  last group of a frame.
- pixels_s_user  in  TUSER_WIDTH  sideband.
- weights_s_valid / weights_s_ready  in/out  1  weight handshake.
- weights_s_data  in  CORES×DATA_WIDTH  signed weights.
- m_valid / m_ready  out/in  1  result handshake.
- m_data  out  CORES×CONV_UNITS×ACC_WIDTH  results.
- m_last  out  1  registered pixels_s_frame_last of the group's last beat.
- m_user  out  TUSER_WIDTH  registered pixels_s_user of the group's last beat.

## Operation
- Registered config mode_max and mode_relu load on start. Reset value of both is 0.
- slot_ok = !m_valid | m_ready.
- accept = !pixels_s_last | slot_ok.
- Conv mode:
  - fire = pixels_s_valid & weights_s_valid & accept.
  - pixels_s_ready = weights_s_valid & accept.
  - weights_s_ready = pixels_s_valid & accept.
- Max mode:
  - fire = pixels_s_valid & accept.
  - pixels_s_ready = accept.
  - weights_s_ready = 0; weights are not consumed.
- Ready signals depend on valid only through the join; no combinational path runs from m_ready to m_valid.
- On fire, for each core c and unit u:
  - conv: acc[c][u] ← (first ? 0 : acc[c][u]) + sext(pix[u]·w[c]).
  - max: acc[c][u] ← first ? sext(pix[u]) : max(acc[c][u], sext(pix[u])), identical for all c.
- Arithmetic is two's complement. The full 2·DATA_WIDTH product is sign-extended. Accumulator overflow wraps silently.
- first is set by reset, by start, and by a fire with pixels_s_last. It is cleared by any other fire.
- When a fire has pixels_s_last:
  - m_data ← final acc_next (with ReLU if enabled and mode_relu).
  - m_user and m_last are captured from that beat.
  - m_valid ← 1.
- m_valid clears on m_ready when no new last-fire occurs in the same cycle.
- A simultaneous m_ready and last-fire overwrites the output with the new result and keeps m_valid = 1.
- start during a group discards the partial sums; the next beat is treated as first. start does not affect a pending output beat.
- Reset mid-operation clears everything; no result is emitted for the aborted group.

## Timing
- Output reset values: m_valid = 0, m_data = 0, m_last = 0, m_user = 0. pixels_s_ready and weights_s_ready are low during reset.
- Latency: m_valid rises the cycle after the last beat fires.
- Throughput: one beat per cycle. A single-beat group (1×1 kernel, cin = 1) sustains one result per cycle while m_ready stays high.
- Under backpressure, non-last beats keep accumulating. Only a last beat stalls, until the output slot frees.
- The multiply-accumulate is one combinational stage, and DSP inference is expected. No further pipelining is added.

## Configuration
- CONV_CORES_RELU_EN defined: the ReLU clamp is applied at output capture when mode_relu = 1.
- CONV_CORES_RELU_EN undefined: the is_relu input is ignored, mode_relu is not built, and results are passed unclamped.

## Structure
- Package conv_cores_pkg holds:
  - the default parameter constants;
  - a typedef for the signed accumulator;
  - the mode enum: MODE_CONV, MODE_MAX.
- One sub-module, conv_mac_lane. It holds one core's CONV_UNITS accumulators and takes fire, first, mode and a weight as inputs. The top level instantiates CORES lanes and owns the join, config latch, first flag and output register.

## Test plan
- Conv, 3-beat group, pix = {1..8}, w = {1,2,3,4} each beat → core c unit u result = 3·u·(c+1) (u numbered 1..8); m_valid rises 1 cycle after the third fire.
- Max mode, beats with pix[0] = -5, 7, 2 and weights_s_valid = 0 → all cores unit 0 = 7; weights_s_ready stays 0.
- Backpressure: m_ready = 0 while a second group's two non-last beats arrive → both accepted; the last beat stalls (pixels_s_ready = 0) until m_ready = 1, and the first result is unchanged while held.
- ReLU (macro defined, is_relu = 1): pix = -3, w = 2 single beat → 0; with the macro undefined → -6.
- start pulsed after 2 of 4 beats, then 4 beats of pix = 1, w = 1 → result 4, not 6.
- aresetn asserted mid-group with m_valid = 1 → all outputs 0 immediately; the next group after release accumulates from zero; m_user and m_last match the last beat's inputs.
